// File: rtl/sap1_ram.sv
`default_nettype none
// ============================================================================
// Module      : sap1_ram
// Description : 16x8 program/data memory for the SAP-1 computer.
//               The read port takes the address held by the memory address
//               register. It drives a registered byte onto the W bus one cycle
//               after the active-low output enable is sampled low.
//               A front-panel loader fills the whole memory in address order.
//               It uses a valid/ready handshake and an auto-incrementing
//               address counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   address      in   [ADDR_WIDTH] read/write address from the MAR
//   enable_out   in   active-low read enable; data appears the next cycle
//   to_BUS       out  [DATA_WIDTH] registered read data, 0 when not driving
//   bus_drive    out  1 while to_BUS carries valid bus data
//   prog_start   in   pulse: begin a full-memory load
//   prog_valid   in   loader byte valid
//   prog_data    in   [DATA_WIDTH] loader byte
//   prog_ready   out  loader byte accepted this cycle
//   prog_busy    out  load in progress
//   prog_done    out  load complete, held until next prog_start or reset
//   from_BUS     in   [DATA_WIDTH] bus write data  (SAP1_RAM_WRITE_EN only)
//   enable_write in   active-low bus write enable (SAP1_RAM_WRITE_EN only)
//
// Build option
//   SAP1_RAM_WRITE_EN : adds a bus write port that is usable outside a load.
//                       When the macro is undefined, the RAM is read-only
//                       except through the loader (classic SAP-1).
// ============================================================================
module sap1_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  enable_out,
`ifdef SAP1_RAM_WRITE_EN
  input  logic [DATA_WIDTH-1:0] from_BUS,
  input  logic                  enable_write,
`endif
  output logic [DATA_WIDTH-1:0] to_BUS,
  output logic                  bus_drive,
  input  logic                  prog_start,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_ready,
  output logic                  prog_busy,
  output logic                  prog_done
);

  localparam int                  c_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0]   r_to_bus;
  logic                    r_bus_drive;

  logic                    w_loading;
  logic                    w_start;
  logic                    w_load_we;
  logic                    w_read;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_waddr;
  logic [DATA_WIDTH-1:0]   w_wdata;

  assign w_loading = (r_state == S_LOAD);
  // prog_start only counts from IDLE or DONE; a pulse in mid-load is ignored.
  assign w_start   = prog_start && !w_loading;
  assign w_load_we = w_loading && prog_valid;
  // Reads are blocked for the whole load so a half-written image is never seen.
  assign w_read    = !w_loading && !enable_out;

  // --------------------------------------------------------------------------
  // Loader state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (prog_start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (prog_valid && (r_cnt == c_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (prog_start) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign prog_busy  = w_loading;
  assign prog_ready = w_loading;
  assign prog_done  = (r_state == S_DONE);

  // --------------------------------------------------------------------------
  // Load address counter. It is modular, so accepting the last word wraps
  // the counter back to 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_load_we) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Write port select: the loader owns the array during LOAD. Otherwise the
  // optional bus write port may write it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_we    = w_load_we;
    w_waddr = r_cnt;
    w_wdata = prog_data;
`ifdef SAP1_RAM_WRITE_EN
    if (!w_loading && !enable_write) begin
      w_we    = 1'b1;
      w_waddr = address;
      w_wdata = from_BUS;
    end
`endif
  end

  // The array is never cleared. Writes are suppressed on a reset edge, so
  // words written before a mid-load reset survive and the rest keep their
  // old contents.
  always_ff @(posedge clock) begin
    if (!reset && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port. The array read uses the pre-edge contents, so a
  // same-edge write to the same address returns the old word.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_to_bus    <= '0;
      r_bus_drive <= 1'b0;
    end else if (w_read) begin
      r_to_bus    <= r_mem[address];
      r_bus_drive <= 1'b1;
    end else begin
      r_to_bus    <= '0;
      r_bus_drive <= 1'b0;
    end
  end

  assign to_BUS    = r_to_bus;
  assign bus_drive = r_bus_drive;

endmodule
`default_nettype wire

// File: tb/tb_sap1_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap1_ram
// Description : Self-checking bench for sap1_ram. Random stimulus is compared
//               against a word-array reference of the memory, plus a simple
//               count of the bytes accepted by the loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap1_ram;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          enable_out;
  logic [DW-1:0] to_BUS;
  logic          bus_drive;
  logic          prog_start;
  logic          prog_valid;
  logic [DW-1:0] prog_data;
  logic          prog_ready;
  logic          prog_busy;
  logic          prog_done;
`ifdef SAP1_RAM_WRITE_EN
  logic [DW-1:0] from_BUS;
  logic          enable_write;
`endif

  sap1_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .enable_out   (enable_out),
`ifdef SAP1_RAM_WRITE_EN
    .from_BUS     (from_BUS),
    .enable_write (enable_write),
`endif
    .to_BUS       (to_BUS),
    .bus_drive    (bus_drive),
    .prog_start   (prog_start),
    .prog_valid   (prog_valid),
    .prog_data    (prog_data),
    .prog_ready   (prog_ready),
    .prog_busy    (prog_busy),
    .prog_done    (prog_done)
  );

  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] m_mem [DEPTH];   // reference image of the memory

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full load of base+n (incr) or a constant base. Stall pattern: 0 = none,
  // 1 = valid 1,0,0 repeating, 2 = random. Reads and prog_start pulses are
  // thrown in during the load, and both must be ignored.
  task automatic run_load(input logic [DW-1:0] base, input bit incr, input int pat);
    int            acc;
    int            busy_cyc;
    int            guard;
    int            k;
    bit            fv;
    logic [DW-1:0] fd;
    acc = 0; busy_cyc = 0; guard = 0; k = 0;
    enable_out = 1'b1;
    prog_valid = 1'b0;
    prog_start = 1'b1;
    step();
    prog_start = 1'b0;
    check("load_busy_start",  int'(prog_busy),  1);
    check("load_ready_start", int'(prog_ready), 1);
    check("load_done_start",  int'(prog_done),  0);
    if (prog_busy) busy_cyc++;
    while (acc < DEPTH && guard < 400) begin
      guard++;
      case (pat)
        0:       prog_valid = 1'b1;
        1:       prog_valid = (k % 3 == 0);
        default: prog_valid = 1'($urandom_range(0, 1));
      endcase
      k++;
      prog_data  = base + (incr ? 8'(acc) : 8'd0);
      enable_out = 1'($urandom_range(0, 1));
      address    = 4'($urandom);
      prog_start = ($urandom_range(0, 7) == 0);
`ifdef SAP1_RAM_WRITE_EN
      enable_write = 1'($urandom_range(0, 1));
      from_BUS     = 8'($urandom);
`endif
      fv = prog_valid;
      fd = prog_data;
      step();
      if (fv) begin
        m_mem[acc] = fd;
        acc++;
      end
      check($sformatf("load_busy_%0d", acc),  int'(prog_busy),  int'(acc < DEPTH));
      check($sformatf("load_ready_%0d", acc), int'(prog_ready), int'(acc < DEPTH));
      check($sformatf("load_done_%0d", acc),  int'(prog_done),  int'(acc == DEPTH));
      check("load_read_blocked_data",  int'(to_BUS),    0);
      check("load_read_blocked_drive", int'(bus_drive), 0);
      if (prog_busy) busy_cyc++;
    end
    if (guard >= 400) check("load_timeout", 0, 1);
    prog_valid = 1'b0;
    prog_start = 1'b0;
    enable_out = 1'b1;
`ifdef SAP1_RAM_WRITE_EN
    enable_write = 1'b1;
`endif
    if (pat == 0) check("busy_cycles", busy_cyc, 16);
  endtask

  // Read every address on consecutive cycles and compare with the reference.
  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      address    = 4'(i);
      enable_out = 1'b0;
      step();
      check($sformatf("%s_data_%0d", tag, i), int'(to_BUS), int'(m_mem[i]));
      check($sformatf("%s_drive_%0d", tag, i), int'(bus_drive), 1);
    end
    enable_out = 1'b1;
    step();
    check($sformatf("%s_oe_drop", tag), int'(bus_drive), 0);
  endtask

  // Random reads (and bus writes when enabled) outside a load. prog_valid
  // pulses are injected here and must not change the memory.
  task automatic read_rand(input int n);
    logic [DW-1:0] exp_d;
    bit            exp_v;
    for (int i = 0; i < n; i++) begin
      enable_out = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      address    = 4'($urandom);
      prog_valid = 1'($urandom_range(0, 1));
      prog_data  = 8'($urandom);
      exp_v      = !enable_out;
      exp_d      = exp_v ? m_mem[address] : 8'd0;
`ifdef SAP1_RAM_WRITE_EN
      enable_write = 1'($urandom_range(0, 1));
      from_BUS     = 8'($urandom);
      if (!enable_write) m_mem[address] = from_BUS;
`endif
      step();
      check("rand_read_data",  int'(to_BUS),     int'(exp_d));
      check("rand_read_drive", int'(bus_drive),  int'(exp_v));
      check("rand_ready_idle", int'(prog_ready), 0);
    end
    prog_valid = 1'b0;
    enable_out = 1'b1;
`ifdef SAP1_RAM_WRITE_EN
    enable_write = 1'b1;
`endif
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    enable_out = 1'b1;
    prog_start = 1'b0;
    prog_valid = 1'b0;
    prog_data  = '0;
`ifdef SAP1_RAM_WRITE_EN
    from_BUS     = '0;
    enable_write = 1'b1;
`endif
    step();
    step();
    check("rst_to_bus", int'(to_BUS),     0);
    check("rst_drive",  int'(bus_drive),  0);
    check("rst_ready",  int'(prog_ready), 0);
    check("rst_busy",   int'(prog_busy),  0);
    check("rst_done",   int'(prog_done),  0);
    reset = 1'b0;
    step();

    // Full load with no stalls, then a directed sequential read.
    run_load(8'h10, 1'b1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      address    = 4'(i);
      enable_out = 1'b0;
      step();
      check($sformatf("seq_read_%0d", i), int'(to_BUS), 16 + i);
      check("seq_drive", int'(bus_drive), 1);
      check("seq_done_held", int'(prog_done), 1);
    end
    enable_out = 1'b1;
    address    = 4'd9;
    step();
    check("oe_off_data",  int'(to_BUS),    0);
    check("oe_off_drive", int'(bus_drive), 0);
    read_rand(40);

    // Stalled load, 1,0,0 valid pattern.
    run_load(8'hA0, 1'b1, 1);
    for (int i = 0; i < DEPTH; i++) begin
      address    = 4'(i);
      enable_out = 1'b0;
      step();
      check($sformatf("stall_read_%0d", i), int'(to_BUS), 160 + i);
    end
    enable_out = 1'b1;
    step();

    // Random stalls with random base.
    run_load(8'($urandom), 1'b1, 2);
    read_all("rnd_load");
    read_rand(40);

    // Reset in mid-load over a 0xEE image.
    run_load(8'hEE, 1'b0, 0);
    prog_start = 1'b1;
    step();
    prog_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h55;
      step();
      m_mem[i] = 8'h55;
    end
    prog_valid = 1'b1;   // held through the reset edge: must not write
    prog_data  = 8'h77;
    reset      = 1'b1;
    step();
    prog_valid = 1'b0;
    reset      = 1'b0;
    check("mid_rst_to_bus", int'(to_BUS),     0);
    check("mid_rst_drive",  int'(bus_drive),  0);
    check("mid_rst_ready",  int'(prog_ready), 0);
    check("mid_rst_busy",   int'(prog_busy),  0);
    check("mid_rst_done",   int'(prog_done),  0);
    address    = 4'd5;
    enable_out = 1'b0;
    step();
    check("mid_rst_addr5", int'(to_BUS), 8'hEE);
    address = 4'd4;
    step();
    check("mid_rst_addr4", int'(to_BUS), 8'h55);
    enable_out = 1'b1;
    read_all("mid_rst");

`ifdef SAP1_RAM_WRITE_EN
    // Same-edge write and read at address 7 return the old word.
    address      = 4'd7;
    from_BUS     = 8'h3C;
    enable_write = 1'b0;
    enable_out   = 1'b0;
    step();
    check("rdw_old", int'(to_BUS), int'(m_mem[7]));
    m_mem[7]     = 8'h3C;
    enable_write = 1'b1;
    step();
    check("rdw_new", int'(to_BUS), 8'h3C);
    enable_out = 1'b1;
    step();
`endif

    // Final load after the reset; it must restart cleanly from address 0.
    run_load(8'($urandom), 1'b1, 2);
    read_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap1_ram.md
Name: sap1_ram

Overview:
- 16x8 program/data memory for the SAP-1. Sits at the far end of the memory address register: it takes the 4-bit address held by that register and drives the addressed byte onto the W bus when the controller asserts the active-low output enable.
- A front-panel loader fills the memory before a run. It uses a valid/ready handshake, an auto-incrementing address counter and a small state machine.

Parameters:
- ADDR_WIDTH, 4, address width; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  RAM address from the memory address register.
- enable_out  input  1  active-low; when 0, the RAM drives the bus on the next cycle.
- to_BUS  output  DATA_WIDTH  registered read data; 0 when not driving.
- bus_drive  output  1  1 while to_BUS is valid bus data (bus mux select).
- prog_start  input  1  single-cycle pulse that begins a full-memory load.
- prog_valid  input  1  loader data valid.
- prog_data  input  DATA_WIDTH  loader byte.
- prog_ready  output  1  RAM accepts prog_data this cycle.
- prog_busy  output  1  load in progress.
- prog_done  output  1  load completed; held until the next prog_start or reset.

Behaviour:
- Clock and reset (decided): single clock named clock; reset named reset, synchronous, active-high.
- Reset values:
  - to_BUS=0, bus_drive=0, prog_ready=0, prog_busy=0, prog_done=0.
  - Loader counter=0, state=IDLE.
  - Memory contents are NOT cleared by reset.
- Loader states: IDLE, LOAD, DONE.
  - IDLE: prog_start=1 -> LOAD, counter<=0, prog_done<=0.
  - LOAD: prog_busy=1, prog_ready=1 (combinational from state).
    - Each cycle with prog_valid=1: mem[counter]<=prog_data, counter<=counter+1.
    - Write of the last address (counter==2**ADDR_WIDTH-1) -> DONE. The counter wraps to 0.
    - prog_valid=0: no write, counter holds. Stalls are unbounded.
  - DONE: prog_done=1, prog_busy=0, prog_ready=0. prog_start=1 -> LOAD, same as from IDLE.
  - prog_start while in LOAD: ignored; the load continues uninterrupted.
  - prog_valid outside LOAD: ignored; no write.
  - Reset mid-load: state returns to IDLE and counter to 0. Words already written stay in memory; unwritten words keep their old contents.
- Read path (IDLE or DONE only):
  - Rising edge with enable_out=0: to_BUS<=mem[address], bus_drive<=1.
  - Rising edge with enable_out=1: to_BUS<=0, bus_drive<=0.
  - Latency: data appears 1 cycle after the enable_out=0 sample. Back-to-back reads with changing address give one word per cycle.
  - The address is sampled on the same edge as enable_out; no internal address register.
- Read during LOAD: enable_out is ignored and to_BUS=0, bus_drive=0. A read never observes a half-loaded memory.
- Read-during-write (optional write port, same address, same edge): to_BUS returns the old word. The new word is visible on the following read.
- Widths: counter is ADDR_WIDTH bits, modular. No arithmetic on data.

Optional Feature:
- Macro: SAP1_RAM_WRITE_EN.
- Defined: adds ports from_BUS (input, DATA_WIDTH) and enable_write (input, 1, active-low).
  - In IDLE/DONE, a rising edge with enable_write=0 writes mem[address]<=from_BUS.
  - enable_write=0 and enable_out=0 together: the write occurs, and the read returns the old word.
  - enable_write is ignored during LOAD.
- Undefined: neither port exists. The RAM is read-only outside the loader; this is the classic SAP-1 configuration.

Test Plan:
- Full load:
  - Stimulus: reset, prog_start, then 16 bytes 0x10..0x1F with prog_valid held high.
  - Response: prog_busy for exactly 16 cycles; prog_done=1 the cycle after the 16th byte; prog_ready=0 thereafter.
  - Then read addresses 0..15 with enable_out=0 on consecutive cycles: to_BUS yields 0x10..0x1F, each one cycle late, with bus_drive=1.
- Stalled load:
  - Stimulus: prog_valid toggled 1,0,0,1,... with bytes 0xA0..0xAF.
  - Response: the counter advances only on valid cycles; final contents mem[n]=0xA0+n; prog_done is not asserted until the 16th accepted byte.
- Read blocked during load:
  - Stimulus: enable_out=0, address=3, mid-load.
  - Response: to_BUS=0x00, bus_drive=0.
  - Stimulus: prog_start pulsed mid-load.
  - Response: the load is not restarted; the count is unaffected.
- Reset mid-load:
  - Stimulus: after 5 bytes 0x55 written over a prior image of 0xEE, assert reset for 1 cycle.
  - Response: IDLE; all outputs 0.
  - Read check: addresses 0..4 read 0x55 and address 5 reads 0xEE.
- Output enable deasserted:
  - Stimulus: enable_out=1 with any address.
  - Response: to_BUS=0x00, bus_drive=0 one cycle later.
  - Stimulus: enable_out goes 0 -> 1.
  - Response: bus_drive drops on the next edge.
- SAP1_RAM_WRITE_EN defined:
  - Stimulus: enable_write=0, address=7, from_BUS=0x3C, with simultaneous enable_out=0.
  - Response: to_BUS returns the old mem[7]; the next read of address 7 gives 0x3C.
  - Stimulus: enable_write=0 during LOAD.
  - Response: no change to memory.
